// File: rtl/dfd_te_mso_dec.sv
// MSEO trace-stream decoder: reassembles {MDO, MSEO} bytes into LSB-first fields
// with first/last/overflow tags and flags reserved MSEO codes.
module dfd_te_mso_dec #(
   parameter int MDO_BITS   = 6,
   parameter int MSO_BITS   = 2,
   parameter int DATA_WIDTH = 64,
   parameter int MAX_BYTES  = (DATA_WIDTH + MDO_BITS - 1) / MDO_BITS
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          byte_valid,
   input  logic [MDO_BITS+MSO_BITS-1:0]  byte_in,
   output logic                          byte_ready,
   output logic                          field_valid,
   input  logic                          field_ready,
   output logic [DATA_WIDTH-1:0]         field_data,
   output logic [$clog2(MAX_BYTES):0]    field_len_bytes,
   output logic                          field_first,
   output logic                          field_last,
   output logic                          field_ovf,
   output logic                          proto_err
);

   localparam int LEN_W = $clog2(MAX_BYTES) + 1;

   localparam logic [MSO_BITS-1:0] MSEO_CONT      = MSO_BITS'(2'b00);
   localparam logic [MSO_BITS-1:0] MSEO_END_FIELD = MSO_BITS'(2'b01);
   localparam logic [MSO_BITS-1:0] MSEO_RSVD      = MSO_BITS'(2'b10);
   localparam logic [MSO_BITS-1:0] MSEO_END_MSG   = MSO_BITS'(2'b11);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_MSG    = 2'd1,
      S_RESYNC = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   acc_q, acc_d;
   logic [LEN_W-1:0]        cnt_q, cnt_d;
   logic                    first_q, first_d;
   logic                    ovf_q, ovf_d;
   logic                    perr_d;

   logic                    load;
   logic [DATA_WIDTH-1:0]   ld_data;
   logic [LEN_W-1:0]        ld_len;
   logic                    ld_first, ld_last, ld_ovf;

   logic                    accept;
   logic [MSO_BITS-1:0]     mseo;
   logic [DATA_WIDTH-1:0]   mdo_ext;
   logic [31:0]             shamt;
   logic                    at_max;
   logic [DATA_WIDTH-1:0]   merged;

   assign byte_ready = !(field_valid && !field_ready);
   assign accept     = byte_valid && byte_ready;
   assign mseo       = byte_in[MSO_BITS-1:0];
   assign mdo_ext    = DATA_WIDTH'(byte_in[MDO_BITS+MSO_BITS-1:MSO_BITS]);
   assign shamt      = 32'(MDO_BITS) * 32'(cnt_q);
   assign at_max     = (cnt_q == LEN_W'(MAX_BYTES));
   // Once the field is full, extra bytes are dropped rather than shifted in.
   assign merged     = at_max ? acc_q : (acc_q | (mdo_ext << shamt));

   // NOTE: every output of this block gets a default first so no path infers a latch.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      first_d  = first_q;
      ovf_d    = ovf_q;
      perr_d   = 1'b0;
      load     = 1'b0;
      ld_data  = '0;
      ld_len   = '0;
      ld_first = 1'b0;
      ld_last  = 1'b0;
      ld_ovf   = 1'b0;

      if (accept) begin
         unique case (state_q)
            S_IDLE: begin
               if (mseo == MSEO_CONT) begin
                  acc_d   = mdo_ext;
                  cnt_d   = LEN_W'(1);
                  first_d = 1'b1;
                  ovf_d   = 1'b0;
                  state_d = S_MSG;
               end else if (mseo == MSEO_END_FIELD) begin
                  load     = 1'b1;
                  ld_data  = mdo_ext;
                  ld_len   = LEN_W'(1);
                  ld_first = 1'b1;
                  acc_d    = '0;
                  cnt_d    = '0;
                  first_d  = 1'b0;
                  ovf_d    = 1'b0;
                  state_d  = S_MSG;
               end else if (mseo == MSEO_RSVD) begin
                  perr_d  = 1'b1;
                  acc_d   = '0;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
                  state_d = S_RESYNC;
               end
            end

            S_MSG: begin
               if (mseo == MSEO_RSVD) begin
                  perr_d  = 1'b1;
                  acc_d   = '0;
                  cnt_d   = '0;
                  first_d = 1'b0;
                  ovf_d   = 1'b0;
                  state_d = S_RESYNC;
               end else if (mseo == MSEO_CONT) begin
                  acc_d = merged;
                  cnt_d = at_max ? cnt_q : cnt_q + LEN_W'(1);
                  ovf_d = ovf_q || at_max;
               end else begin
                  // A terminator arriving on a full field is itself one byte too many.
                  load     = 1'b1;
                  ld_data  = merged;
                  ld_len   = at_max ? cnt_q : cnt_q + LEN_W'(1);
                  ld_first = first_q;
                  ld_last  = (mseo == MSEO_END_MSG);
                  ld_ovf   = ovf_q || at_max;
                  acc_d    = '0;
                  cnt_d    = '0;
                  first_d  = 1'b0;
                  ovf_d    = 1'b0;
                  state_d  = (mseo == MSEO_END_MSG) ? S_IDLE : S_MSG;
               end
            end

            S_RESYNC: begin
               if (mseo == MSEO_END_MSG) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         first_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         first_q <= first_d;
         ovf_q   <= ovf_d;
      end
   end

   // Field holding register: loads only when a byte is accepted, which implies the slot is free.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         field_valid     <= 1'b0;
         field_data      <= '0;
         field_len_bytes <= '0;
         field_first     <= 1'b0;
         field_last      <= 1'b0;
         field_ovf       <= 1'b0;
         proto_err       <= 1'b0;
      end else begin
         proto_err <= perr_d;
         if (load) begin
            field_valid     <= 1'b1;
            field_data      <= ld_data;
            field_len_bytes <= ld_len;
            field_first     <= ld_first;
            field_last      <= ld_last;
            field_ovf       <= ld_ovf;
         end else if (field_ready) begin
            field_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dfd_te_mso_dec.sv
// Self-checking bench for dfd_te_mso_dec: directed protocol cases followed by
// randomized traffic scored against a byte-list model of the MSEO framing rules.
module tb_dfd_te_mso_dec;

   localparam int MAX_BYTES = 11;

   logic        clk = 1'b0;
   logic        reset;
   logic        byte_valid;
   logic [7:0]  byte_in;
   logic        byte_ready;
   logic        field_valid;
   logic        field_ready;
   logic [63:0] field_data;
   logic [4:0]  field_len_bytes;
   logic        field_first;
   logic        field_last;
   logic        field_ovf;
   logic        proto_err;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: message mode, bytes of the field in progress, and the expected output slot.
   int          m_mode;      // 0 between messages, 1 inside a message, 2 discarding
   logic [5:0]  m_q[$];
   bit          m_first;
   bit          m_fv;
   logic [63:0] m_fd;
   int          m_len;
   bit          m_ff, m_fl, m_fo;
   bit          m_perr;

   always #5 clk = ~clk;

   dfd_te_mso_dec dut (
      .clk             (clk),
      .reset           (reset),
      .byte_valid      (byte_valid),
      .byte_in         (byte_in),
      .byte_ready      (byte_ready),
      .field_valid     (field_valid),
      .field_ready     (field_ready),
      .field_data      (field_data),
      .field_len_bytes (field_len_bytes),
      .field_first     (field_first),
      .field_last      (field_last),
      .field_ovf       (field_ovf),
      .proto_err       (proto_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0;
      m_q.delete();
      m_first = 0;
      m_fv = 0;
      m_fd = '0;
      m_len = 0;
      m_ff = 0;
      m_fl = 0;
      m_fo = 0;
      m_perr = 0;
   endtask

   // A field is the first MAX_BYTES stored bytes placed 6 bits apart, truncated to 64 bits.
   task automatic emit(input bit last);
      int n;
      n = m_q.size();
      m_fd = '0;
      for (int i = 0; i < n && i < MAX_BYTES; i++) m_fd |= 64'(m_q[i]) << (6 * i);
      m_len = (n > MAX_BYTES) ? MAX_BYTES : n;
      m_fo  = (n > MAX_BYTES);
      m_ff  = m_first;
      m_fl  = last;
      m_fv  = 1;
      m_q.delete();
      m_first = 0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic [1:0] mseo;
      logic [5:0] mdo;
      mseo = b[1:0];
      mdo  = b[7:2];
      case (m_mode)
         0: begin
            if (mseo == 2'b00) begin
               m_q = {mdo}; m_first = 1; m_mode = 1;
            end else if (mseo == 2'b01) begin
               m_q = {mdo}; m_first = 1; emit(0); m_mode = 1;
            end else if (mseo == 2'b10) begin
               m_perr = 1; m_q.delete(); m_mode = 2;
            end
         end
         1: begin
            if (mseo == 2'b10) begin
               m_perr = 1; m_q.delete(); m_first = 0; m_mode = 2;
            end else begin
               m_q.push_back(mdo);
               if (mseo == 2'b01) emit(0);
               else if (mseo == 2'b11) begin
                  emit(1); m_mode = 0;
               end
            end
         end
         default: if (mseo == 2'b11) m_mode = 0;
      endcase
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".field_valid"}, field_valid, m_fv);
      chk({tag, ".proto_err"}, proto_err, m_perr);
      if (m_fv) begin
         chk({tag, ".field_data"}, field_data, m_fd);
         chk({tag, ".field_len"}, field_len_bytes, 64'(m_len));
         chk({tag, ".field_first"}, field_first, m_ff);
         chk({tag, ".field_last"}, field_last, m_fl);
         chk({tag, ".field_ovf"}, field_ovf, m_fo);
      end
   endtask

   // One clock: drive, check ready, advance model, then sample 1 time unit after the edge.
   task automatic step(input bit v, input logic [7:0] b, input bit fr, input string tag);
      bit exp_ready;
      byte_valid  = v;
      byte_in     = b;
      field_ready = fr;
      #1;
      exp_ready = !(m_fv && !fr);
      chk({tag, ".byte_ready"}, byte_ready, exp_ready);
      if (m_fv && fr) m_fv = 0;
      m_perr = 0;
      if (v && exp_ready) model_byte(b);
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      byte_valid = 1'b0;
      field_ready = 1'b0;
      #1;
      model_reset();
      chk({tag, ".ready_in_reset"}, byte_ready, 1'b1);
      chk({tag, ".zero_outputs"},
          {field_valid, field_data, field_len_bytes, field_first, field_last, field_ovf, proto_err},
          '0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk({tag, ".ready_after_reset"}, byte_ready, 1'b1);
   endtask

   initial begin
      byte_valid = 1'b0;
      byte_in = '0;
      field_ready = 1'b0;
      reset = 1'b0;
      model_reset();
      #2;
      do_reset("rst0");

      // Two-byte message, one field.
      step(1, 8'h04, 1, "m36a");
      step(1, 8'h0B, 1, "m36b");
      chk("m36.data", field_data, 64'h81);
      chk("m36.len", field_len_bytes, 5'd2);
      chk("m36.flags", {field_valid, field_first, field_last, field_ovf}, 4'b1110);
      step(0, 8'h00, 1, "m36c");

      // One-byte field from idle, then closing one-byte field.
      step(1, 8'h05, 1, "m37a");
      chk("m37a.fields", {field_data[7:0], field_len_bytes, field_first, field_last}, {8'h01, 5'd1, 2'b10});
      step(1, 8'h0F, 1, "m37b");
      chk("m37b.fields", {field_data[7:0], field_len_bytes, field_first, field_last}, {8'h03, 5'd1, 2'b01});
      step(0, 8'h00, 1, "m37c");

      // Overflow: 13 bytes into an 11-byte field.
      step(1, 8'h04, 1, "m38s");
      for (int i = 0; i < 11; i++) step(1, 8'hFC, 1, "m38c");
      step(1, 8'hFF, 1, "m38e");
      chk("m38.data", field_data, 64'hFFFF_FFFF_FFFF_FFC1);
      chk("m38.len_ovf_last", {field_len_bytes, field_ovf, field_last}, {5'd11, 2'b11});

      // Backpressure: pending field blocks input, then consumption and acceptance coincide.
      step(1, 8'h04, 0, "m39a");
      step(1, 8'h04, 0, "m39b");
      chk("m39.stalled", byte_ready, 1'b0);
      chk("m39.stable", field_data, 64'hFFFF_FFFF_FFFF_FFC1);
      step(1, 8'h04, 1, "m39c");
      chk("m39.consumed", field_valid, 1'b0);
      step(1, 8'h0B, 1, "m39d");
      chk("m39.data", field_data, 64'h81);
      step(0, 8'h00, 1, "m39e");

      // Reserved MSEO: one error pulse, resync until end-of-message.
      step(1, 8'h04, 1, "m40a");
      step(1, 8'h06, 1, "m40b");
      chk("m40.perr", proto_err, 1'b1);
      step(1, 8'h08, 1, "m40c");
      step(1, 8'h06, 1, "m40d");
      chk("m40.no_repulse", proto_err, 1'b0);
      step(1, 8'h03, 1, "m40e");
      step(1, 8'h04, 1, "m40f");
      step(1, 8'h0B, 1, "m40g");
      chk("m40.data_len", {field_data, field_len_bytes}, {64'h81, 5'd2});
      step(0, 8'h00, 1, "m40h");

      // Reset mid-message, then a clean message.
      step(1, 8'h04, 1, "m41a");
      step(1, 8'h08, 1, "m41b");
      do_reset("m41r");
      step(1, 8'h04, 1, "m41c");
      step(1, 8'h0B, 1, "m41d");
      chk("m41.result", {field_data, field_len_bytes, field_first}, {64'h81, 5'd2, 1'b1});

      // Randomized traffic: long continuation runs first to exercise overflow, then mixed.
      for (int i = 0; i < 3000; i++) begin
         int r, p00;
         logic [1:0] mseo;
         logic [7:0] b;
         if (i == 2000) do_reset("rnd_rst");
         p00 = (i < 1500) ? 92 : 60;
         r = $urandom_range(0, 99);
         if (r < p00) mseo = 2'b00;
         else if (r < 96) mseo = ($urandom_range(0, 1) == 0) ? 2'b11 : 2'b01;
         else if (r < 98) mseo = 2'b01;
         else mseo = 2'b10;
         b = {6'($urandom), mseo};
         step($urandom_range(0, 9) < 8, b, $urandom_range(0, 9) < 7, "rnd");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
